// File: rtl/rv_fetch_pkg.sv
// Shared fetch-side encodings: PC mux select codes, fetch-redirect FSM
// states and the trap cause raised for a misaligned branch target.
package rv_fetch_pkg;

  // PC mux select codes, shared with the stage-1 PC mux
  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  // Fetch-redirect FSM state encoding
  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_TRAP = 2'b10;
  localparam logic [1:0] ST_EPC  = 2'b11;

  // Instruction-address-misaligned exception cause code
  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;

  // Flush counter width
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pc_src_ctrl.sv
// Fetch-redirect controller for the stage-1 PC mux. Sequences boot fetch,
// trap entry, mret return and misaligned-branch traps; every redirect is
// held until the instruction bus accepts the fetch address, after which
// the front end is flushed for FLUSH_CYCLES more cycles.
module pc_src_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_SRC_W     = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                ahb_ready_in,
  input  logic                stall_in,
  input  logic                branch_taken_in,
  input  logic                misaligned_instr_in,
  input  logic                trap_taken_in,
  input  logic                mret_in,
  output logic [PC_SRC_W-1:0] pc_src_out,
  output logic                pc_write_en_out,
  output logic                flush_out,
  output logic                misaligned_trap_out,
  output logic                redirect_busy_out
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  logic [1:0]             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   mis_trap_q, mis_trap_d;

  logic [1:0]             pc_src_s;
  logic                   pc_we_s;
  logic                   flush_s;
  logic                   busy_s;

  // Next-state, flush counter and output decode for the redirect FSM
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    mis_trap_d  = 1'b0;
    pc_src_s    = PC_SRC_BOOT;
    pc_we_s     = 1'b0;
    flush_s     = 1'b1;
    busy_s      = 1'b1;

    case (state_q)
      ST_BOOT: begin
        pc_src_s = PC_SRC_BOOT;
        pc_we_s  = ahb_ready_in;
        if (ahb_ready_in) begin
          state_d     = ST_RUN;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          state_d = ST_BOOT;
        end
      end

      ST_RUN: begin
        pc_src_s = PC_SRC_NEXT;
        busy_s   = 1'b0;
        if (flush_cnt_q != {FLUSH_CNT_W{1'b0}}) begin
          flush_cnt_d = flush_cnt_q - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          flush_cnt_d = {FLUSH_CNT_W{1'b0}};
        end
        // Redirects never load the PC here; the target is loaded once the
        // bus accepts it from the TRAP/EPC state.
        if (trap_taken_in) begin
          state_d = ST_TRAP;
          pc_we_s = 1'b0;
          flush_s = 1'b1;
        end else if (mret_in) begin
          state_d = ST_EPC;
          pc_we_s = 1'b0;
          flush_s = 1'b1;
        end else if (branch_taken_in && misaligned_instr_in) begin
          state_d    = ST_TRAP;
          pc_we_s    = 1'b0;
          flush_s    = 1'b1;
          mis_trap_d = 1'b1;
        end else begin
          state_d = ST_RUN;
          pc_we_s = ahb_ready_in && !stall_in;
          flush_s = (flush_cnt_q != {FLUSH_CNT_W{1'b0}});
        end
      end

      ST_TRAP: begin
        pc_src_s = PC_SRC_TRAP;
        pc_we_s  = ahb_ready_in;
        // A late mret is dropped; the CSR unit re-issues it if still needed.
        if (ahb_ready_in) begin
          state_d     = ST_RUN;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          state_d = ST_TRAP;
        end
      end

      ST_EPC: begin
        pc_src_s = PC_SRC_EPC;
        pc_we_s  = ahb_ready_in;
        // A trap arriving during the mret return takes over the redirect.
        if (trap_taken_in) begin
          state_d = ST_TRAP;
        end else if (ahb_ready_in) begin
          state_d     = ST_RUN;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          state_d = ST_EPC;
        end
      end

      default: begin
        state_d     = ST_BOOT;
        flush_cnt_d = {FLUSH_CNT_W{1'b0}};
      end
    endcase

    // While reset is held, present the boot redirect regardless of state.
    if (rst_in) begin
      pc_src_s   = PC_SRC_BOOT;
      pc_we_s    = 1'b0;
      flush_s    = 1'b1;
      busy_s     = 1'b1;
      mis_trap_d = 1'b0;
    end else begin
      mis_trap_d = mis_trap_d;
    end
  end

  // State, flush counter and misaligned-pulse registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_BOOT;
      flush_cnt_q <= {FLUSH_CNT_W{1'b0}};
      mis_trap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mis_trap_q  <= mis_trap_d;
    end
  end

  assign pc_src_out          = PC_SRC_W'(pc_src_s);
  assign pc_write_en_out     = pc_we_s;
  assign flush_out           = flush_s;
  assign redirect_busy_out   = busy_s;
  assign misaligned_trap_out = mis_trap_q;

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Directed testbench for pc_src_ctrl with hand-computed expected outputs.
module tb_pc_src_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       ahb_ready_in;
  logic       stall_in;
  logic       branch_taken_in;
  logic       misaligned_instr_in;
  logic       trap_taken_in;
  logic       mret_in;
  logic [1:0] pc_src_out;
  logic       pc_write_en_out;
  logic       flush_out;
  logic       misaligned_trap_out;
  logic       redirect_busy_out;

  int n_checks = 0;
  int n_errors = 0;

  pc_src_ctrl #(.FLUSH_CYCLES(2), .PC_SRC_W(2)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .ahb_ready_in        (ahb_ready_in),
    .stall_in            (stall_in),
    .branch_taken_in     (branch_taken_in),
    .misaligned_instr_in (misaligned_instr_in),
    .trap_taken_in       (trap_taken_in),
    .mret_in             (mret_in),
    .pc_src_out          (pc_src_out),
    .pc_write_en_out     (pc_write_en_out),
    .flush_out           (flush_out),
    .misaligned_trap_out (misaligned_trap_out),
    .redirect_busy_out   (redirect_busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Compare all outputs of the current cycle against expectations
  task automatic expect_outs(input string tag, input logic [1:0] src, input logic we,
                             input logic fl, input logic busy, input logic mis);
    #1;
    check_val({tag, "_src"},  {6'd0, pc_src_out},          {6'd0, src});
    check_val({tag, "_we"},   {7'd0, pc_write_en_out},     {7'd0, we});
    check_val({tag, "_fl"},   {7'd0, flush_out},           {7'd0, fl});
    check_val({tag, "_busy"}, {7'd0, redirect_busy_out},   {7'd0, busy});
    check_val({tag, "_mis"},  {7'd0, misaligned_trap_out}, {7'd0, mis});
  endtask

  // Advance one clock: through the rising edge to the next falling edge
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    rst_in = 1'b1; ahb_ready_in = 1'b0; stall_in = 1'b0;
    branch_taken_in = 1'b0; misaligned_instr_in = 1'b0;
    trap_taken_in = 1'b0; mret_in = 1'b0;

    // Reset held for three cycles (misaligned pulse is known only after an edge)
    #1;
    check_val("rst0_src", {6'd0, pc_src_out}, 8'd0);
    check_val("rst0_we",  {7'd0, pc_write_en_out}, 8'd0);
    step();
    expect_outs("rst1", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_outs("rst2", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step();

    // Boot: bus not ready for two cycles, then ready
    rst_in = 1'b0;
    expect_outs("boot_w1", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_outs("boot_w2", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    ahb_ready_in = 1'b1;
    expect_outs("boot_rdy", 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    expect_outs("run_fl1", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect_outs("run_fl2", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    // Normal fetch with stall toggling
    stall_in = 1'b0;
    expect_outs("stall0", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    stall_in = 1'b1;
    expect_outs("stall1", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    stall_in = 1'b0;
    expect_outs("stall2", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // Trap entry with three bus wait cycles
    trap_taken_in = 1'b1; ahb_ready_in = 1'b0;
    expect_outs("trap_det", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    trap_taken_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_outs($sformatf("trap_wait%0d", i), 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
    end
    ahb_ready_in = 1'b1;
    expect_outs("trap_acc", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    expect_outs("trap_ret1", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect_outs("trap_ret2", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect_outs("trap_ret3", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);

    // Simultaneous trap and mret: trap wins
    trap_taken_in = 1'b1; mret_in = 1'b1;
    expect_outs("sim_det", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    trap_taken_in = 1'b0; mret_in = 1'b0; ahb_ready_in = 1'b0;
    expect_outs("sim_trap", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    ahb_ready_in = 1'b1;
    expect_outs("sim_acc", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    step();
    step();
    expect_outs("sim_run", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);

    // Misaligned branch held high for three cycles
    branch_taken_in = 1'b1; misaligned_instr_in = 1'b1;
    expect_outs("mis_det", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    ahb_ready_in = 1'b0;
    expect_outs("mis_p1", 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    expect_outs("mis_p2", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    branch_taken_in = 1'b0; misaligned_instr_in = 1'b0; ahb_ready_in = 1'b1;
    expect_outs("mis_acc", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    step();
    step();
    expect_outs("mis_run", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);

    // mret with bus held off, then reset mid-redirect
    mret_in = 1'b1; ahb_ready_in = 1'b0;
    expect_outs("mret_det", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    expect_outs("epc_hold1", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_outs("epc_hold2", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    rst_in = 1'b1;
    expect_outs("epc_rst", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    rst_in = 1'b0; mret_in = 1'b0;
    expect_outs("post_rst", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_outs("post_rst2", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
